// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed N-digit seven-segment driver with
// inter-digit blanking. Define SEVEN_SEGMENT_BCD_EN to show value in decimal
// (double-dabble conversion); otherwise value is shown in hex and busy is 0.
module seven_segment_scanner #(
  parameter int unsigned DIGITS       = 2,
  parameter int unsigned CLK_HZ       = 12000000,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned ACTIVE_LOW   = 0,
  parameter int unsigned VALUE_W      = 4*DIGITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  output logic               busy,
  output logic [6:0]         seg,
  output logic [DIGITS-1:0]  digit_sel
);

  localparam int unsigned DIV    = CLK_HZ / (REFRESH_HZ * DIGITS);
  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BLK_W  = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam int unsigned DISP_W = 4 * DIGITS;
  localparam logic [6:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] SEL_OFF = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
      4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h07;
      4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
      4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  4'hF: font = 7'h71;
      default: font = 7'h00;
    endcase
  endfunction

  // Reset synchroniser: asserts asynchronously, releases on clk.
  logic [1:0] rst_pipe_q, rst_pipe_d;
  logic       rst_int;

  always_comb rst_pipe_d = {rst_pipe_q[0], 1'b0};

  // Reset pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_pipe_q <= 2'b11;
    else       rst_pipe_q <= rst_pipe_d;
  end

  assign rst_int = rst_pipe_q[1];

  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic              dash_q, dash_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic              tick_c;
  logic [3:0]        nibble_c;
  logic [6:0]        glyph_c;

  // Refresh divider, digit index and post-switch blanking counter.
  always_comb begin
    tick_c = (div_q == DIV_W'(DIV - 1));
    div_d  = tick_c ? '0 : div_q + DIV_W'(1);
    idx_d  = idx_q;
    blk_d  = blk_q;
    if (tick_c) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      blk_d = BLK_W'(BLANK_CYCLES);
    end else if (blk_q != '0) begin
      blk_d = blk_q - BLK_W'(1);
    end
  end

  // Pin drive for the current digit; polarity applied by XOR with the off pattern.
  always_comb begin
    nibble_c = disp_q[{idx_q, 2'b00} +: 4];
    glyph_c  = dash_q ? 7'h40 : font(nibble_c);
    seg_d    = SEG_OFF;
    sel_d    = SEL_OFF;
    if (blk_q == '0) begin
      seg_d = glyph_c ^ SEG_OFF;
      sel_d = (DIGITS'(1) << idx_q) ^ SEL_OFF;
    end
  end

  // Scan and output registers.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      div_q  <= '0;
      idx_q  <= '0;
      blk_q  <= '0;
      disp_q <= '0;
      dash_q <= 1'b0;
      seg_q  <= SEG_OFF;
      sel_q  <= SEL_OFF;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      blk_q  <= blk_d;
      disp_q <= disp_d;
      dash_q <= dash_d;
      seg_q  <= seg_d;
      sel_q  <= sel_d;
    end
  end

  assign seg       = seg_q;
  assign digit_sel = sel_q;

`ifdef SEVEN_SEGMENT_BCD_EN
  localparam int unsigned CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;

  function automatic longint unsigned pow10(input int unsigned n);
    pow10 = 1;
    for (int unsigned i = 0; i < n; i++) pow10 = pow10 * 10;
  endfunction

  localparam longint unsigned MAX_DEC = pow10(DIGITS) - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_COMMIT} state_t;

  state_t             state_q, state_d;
  logic [DISP_W-1:0]  bcd_q, bcd_d, bcd_adj_c;
  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;

  // Double-dabble correction: add 3 to every BCD nibble >= 5 before the shift.
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Conversion FSM: next state, datapath and display commit.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    disp_d  = disp_q;
    dash_d  = dash_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = (64'(value) > MAX_DEC);
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        {bcd_d, bin_d} = {bcd_adj_c, bin_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        disp_d  = bcd_q;
        dash_d  = ovf_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Conversion FSM registers.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
`else
  // Hex mode: capture the low nibbles directly on load; never busy.
  always_comb begin
    disp_d = disp_q;
    dash_d = 1'b0;
    if (load) disp_d = DISP_W'(value);
  end

  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner (DIV=6, BLANK_CYCLES=2, two digits).
module tb_seven_segment_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] value, value_al;
  logic       load, load_al;
  logic       busy, busy_al;
  logic [6:0] seg, seg_al;
  logic [1:0] digit_sel, digit_sel_al;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .DIGITS(2), .CLK_HZ(1200), .REFRESH_HZ(100), .BLANK_CYCLES(2), .ACTIVE_LOW(0), .VALUE_W(8)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .busy(busy), .seg(seg), .digit_sel(digit_sel)
  );

  seven_segment_scanner #(
    .DIGITS(2), .CLK_HZ(1200), .REFRESH_HZ(100), .BLANK_CYCLES(2), .ACTIVE_LOW(1), .VALUE_W(8)
  ) dut_al (
    .clk(clk), .reset(reset), .value(value_al), .load(load_al),
    .busy(busy_al), .seg(seg_al), .digit_sel(digit_sel_al)
  );

  typedef struct {
    logic [7:0] value;
    logic       load;
    logic [1:0] sel;
    logic [6:0] seg;
    logic [1:0] sel_al;
    logic [6:0] seg_al;
  } row_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the main instance drives the given digit, then check its segments.
  task automatic wait_digit(input logic [1:0] sel_val, input logic [6:0] exp_seg, input string name);
    bit found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (digit_sel == sel_val) found = 1'b1;
    end
    check({name, " seen"}, 32'(found), 32'(1));
    if (found) check(name, 32'(seg), 32'(exp_seg));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    row_t rows[25];
    bit   found;
    logic [1:0] prev;

    rows[0]  = '{8'h00, 1'b0, 2'b10, 7'h77, 2'b01, 7'h79};
    rows[1]  = '{8'h00, 1'b0, 2'b10, 7'h77, 2'b01, 7'h79};
    rows[2]  = '{8'h00, 1'b0, 2'b10, 7'h77, 2'b01, 7'h79};
    rows[3]  = '{8'h00, 1'b0, 2'b10, 7'h77, 2'b01, 7'h79};
    rows[4]  = '{8'h00, 1'b0, 2'b00, 7'h00, 2'b11, 7'h7F};
    rows[5]  = '{8'h00, 1'b0, 2'b00, 7'h00, 2'b11, 7'h7F};
    rows[6]  = '{8'h00, 1'b0, 2'b01, 7'h6D, 2'b10, 7'h40};
    rows[7]  = '{8'h00, 1'b0, 2'b01, 7'h6D, 2'b10, 7'h40};
    rows[8]  = '{8'h00, 1'b0, 2'b01, 7'h6D, 2'b10, 7'h40};
    rows[9]  = '{8'h00, 1'b0, 2'b01, 7'h6D, 2'b10, 7'h40};
    rows[10] = '{8'h00, 1'b0, 2'b00, 7'h00, 2'b11, 7'h7F};
    rows[11] = '{8'h00, 1'b0, 2'b00, 7'h00, 2'b11, 7'h7F};
    rows[12] = '{8'h00, 1'b0, 2'b10, 7'h77, 2'b01, 7'h79};
    rows[13] = '{8'h00, 1'b0, 2'b10, 7'h77, 2'b01, 7'h79};
    rows[14] = '{8'h00, 1'b0, 2'b10, 7'h77, 2'b01, 7'h79};
    rows[15] = '{8'h12, 1'b1, 2'b10, 7'h77, 2'b01, 7'h79};
    rows[16] = '{8'h00, 1'b0, 2'b00, 7'h00, 2'b11, 7'h7F};
    rows[17] = '{8'h00, 1'b0, 2'b00, 7'h00, 2'b11, 7'h7F};
    rows[18] = '{8'h00, 1'b0, 2'b01, 7'h5B, 2'b10, 7'h40};
    rows[19] = '{8'h00, 1'b0, 2'b01, 7'h5B, 2'b10, 7'h40};
    rows[20] = '{8'h00, 1'b0, 2'b01, 7'h5B, 2'b10, 7'h40};
    rows[21] = '{8'h00, 1'b0, 2'b01, 7'h5B, 2'b10, 7'h40};
    rows[22] = '{8'h00, 1'b0, 2'b00, 7'h00, 2'b11, 7'h7F};
    rows[23] = '{8'h00, 1'b0, 2'b00, 7'h00, 2'b11, 7'h7F};
    rows[24] = '{8'h00, 1'b0, 2'b10, 7'h06, 2'b01, 7'h79};

    // Reset held with load asserted: everything stays off.
    reset = 1'b1; value = 8'hFF; load = 1'b1; value_al = 8'hFF; load_al = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst seg", 32'(seg), 32'(7'h00));
      check("rst sel", 32'(digit_sel), 32'(2'b00));
      check("rst busy", 32'(busy), 32'(1'b0));
      check("rst seg_al", 32'(seg_al), 32'(7'h7F));
      check("rst sel_al", 32'(digit_sel_al), 32'(2'b11));
    end

`ifndef SEVEN_SEGMENT_BCD_EN
    // Hex scan: A5 on the main instance, 10 on the inverted instance.
    value = 8'hA5; value_al = 8'h10;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    load = 1'b0; load_al = 1'b0;

    // Align on the first switch from blank to digit 1.
    found = 1'b0;
    prev  = digit_sel;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (prev == 2'b00 && digit_sel == 2'b10) found = 1'b1;
      else prev = digit_sel;
    end
    check("align digit1", 32'(found), 32'(1));

    for (int i = 0; i < 25; i++) begin
      if (i > 0) begin
        value = rows[i].value;
        load  = rows[i].load;
        step();
      end
      check($sformatf("row%0d sel", i), 32'(digit_sel), 32'(rows[i].sel));
      check($sformatf("row%0d seg", i), 32'(seg), 32'(rows[i].seg));
      check($sformatf("row%0d sel_al", i), 32'(digit_sel_al), 32'(rows[i].sel_al));
      check($sformatf("row%0d seg_al", i), 32'(seg_al), 32'(rows[i].seg_al));
      check($sformatf("row%0d busy", i), 32'(busy), 32'(1'b0));
    end
`else
    reset = 1'b0; load = 1'b0; load_al = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // 42: busy for 9 cycles; a load mid-conversion is dropped.
    value = 8'd42; load = 1'b1;
    step();
    load = 1'b0;
    for (int j = 0; j < 9; j++) begin
      check($sformatf("bcd busy%0d", j), 32'(busy), 32'(1'b1));
      if (j == 2) begin value = 8'd99; load = 1'b1; end
      else load = 1'b0;
      step();
    end
    load = 1'b0;
    check("bcd busy done", 32'(busy), 32'(1'b0));
    wait_digit(2'b01, 7'h5B, "bcd42 d0");
    wait_digit(2'b10, 7'h66, "bcd42 d1");
    check("bcd idle after", 32'(busy), 32'(1'b0));

    // 100 does not fit in two digits: dashes.
    value = 8'd100; load = 1'b1;
    step();
    load = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (!busy) found = 1'b1;
    end
    check("bcd100 done", 32'(found), 32'(1));
    step();
    wait_digit(2'b01, 7'h40, "bcd100 d0");
    wait_digit(2'b10, 7'h40, "bcd100 d1");

    // Reset mid-conversion clears everything at once.
    value = 8'd57; load = 1'b1;
    step();
    load = 1'b0;
    step();
    check("bcd57 busy", 32'(busy), 32'(1'b1));
    reset = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'(1'b0));
    check("midrst sel", 32'(digit_sel), 32'(2'b00));
    check("midrst seg", 32'(seg), 32'(7'h00));
    step();
    reset = 1'b0;
    wait_digit(2'b01, 7'h3F, "midrst d0");
    wait_digit(2'b10, 7'h3F, "midrst d1");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
